// File: rtl/uart_ahb_bridge_pkg.sv
// Shared types and constants for the UART command to AHB-Lite master bridge.
// Holds the FSM state enum, command codes, AHB encodings and shift-register control payload.
package uart_ahb_bridge_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned CNT_W     = 2;
  localparam int unsigned RSP_CNT_W = 3;

  localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h57;
  localparam logic [BYTE_W-1:0] CMD_READ  = 8'h52;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

  typedef enum logic [2:0] {
    CMD,
    ADDR,
    WDATA,
    BUS_ADDR,
    BUS_DATA,
    RESP
  } state_e;

  // Control payload for one byte_shift32 instance; load has priority over shift.
  typedef struct packed {
    logic              load;
    logic              shift;
    logic [BYTE_W-1:0] shift_in;
    logic [WORD_W-1:0] load_data;
  } shift_ctl_t;

  function automatic logic is_cmd(input logic [BYTE_W-1:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

  function automatic shift_ctl_t load_word(input logic [WORD_W-1:0] w);
    shift_ctl_t c;
    c           = '0;
    c.load      = 1'b1;
    c.load_data = w;
    return c;
  endfunction

endpackage

// File: rtl/uart_ahb_bridge_byte_shift32.sv
// 4-byte MSB-first shift register: collects bytes at the LSB end, serialises from the MSB end.
// A parallel load replaces the whole word (used for bus read data and response bytes).
module byte_shift32
  import uart_ahb_bridge_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  shift_ctl_t        ctl,
  output logic [WORD_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (ctl.load) begin
      q <= ctl.load_data;
    end else if (ctl.shift) begin
      q <= {q[WORD_W-BYTE_W-1:0], ctl.shift_in};
    end
  end

endmodule

// File: rtl/uart_ahb_bridge.sv
// Byte-stream command interpreter ('W'/'R' + address [+ data]) driving a single AHB-Lite master
// transfer at a time and returning ACK/NAK or 4 read-data bytes on the response stream.
module uart_ahb_bridge
  import uart_ahb_bridge_pkg::*;
#(
  parameter logic [7:0] ACK_BYTE = 8'h06,
  parameter logic [7:0] NAK_BYTE = 8'h15
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic        HWRITE,
  output logic [2:0]  HSIZE,
  output logic [31:0] HWDATA,
  input  logic [31:0] HRDATA,
  input  logic        HREADY,
  input  logic        HRESP,
  output logic        busy
);

  localparam logic [WORD_W-1:0] ACK_WORD = {ACK_BYTE, (WORD_W-BYTE_W)'(0)};
  localparam logic [WORD_W-1:0] NAK_WORD = {NAK_BYTE, (WORD_W-BYTE_W)'(0)};

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [RSP_CNT_W-1:0]   rsp_cnt_q, rsp_cnt_d;
  logic                   write_q, write_d;
  logic                   rx_fire, tx_fire;
  logic                   last_byte;
  shift_ctl_t             addr_ctl, data_ctl;
  logic [WORD_W-1:0]      addr_q, data_q;

  // Address register drives HADDR directly; it only moves while bytes arrive in ADDR.
  byte_shift32 u_addr (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .ctl   (addr_ctl),
    .q     (addr_q)
  );

  // Shared data register: write data for HWDATA, then reloaded with the response word.
  byte_shift32 u_data (
    .clk   (HCLK),
    .rst_n (HRESETn),
    .ctl   (data_ctl),
    .q     (data_q)
  );

  assign rx_fire   = rx_valid & rx_ready;
  assign tx_fire   = tx_valid & tx_ready;
  assign last_byte = (cnt_q == CNT_W'(3));

  assign HADDR   = addr_q;
  assign HWDATA  = data_q;
  assign HWRITE  = write_q;
  assign HSIZE   = HSIZE_WORD;
  assign tx_data = data_q[WORD_W-1:WORD_W-BYTE_W];

  // Next-state and datapath control.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    rsp_cnt_d          = rsp_cnt_q;
    write_d            = write_q;
    addr_ctl           = '0;
    addr_ctl.shift_in  = rx_data;
    data_ctl           = '0;
    data_ctl.shift_in  = (state_q == WDATA) ? rx_data : '0;

    unique case (state_q)
      CMD: begin
        if (rx_fire) begin
          if (is_cmd(rx_data)) begin
            write_d = (rx_data == CMD_WRITE);
            cnt_d   = '0;
            state_d = ADDR;
          end else begin
            data_ctl  = load_word(NAK_WORD);
            rsp_cnt_d = RSP_CNT_W'(1);
            state_d   = RESP;
          end
        end
      end

      ADDR: begin
        if (rx_fire) begin
          addr_ctl.shift = 1'b1;
          cnt_d          = cnt_q + CNT_W'(1);
          if (last_byte) begin
            if (write_q) begin
              state_d = WDATA;
            end else if (rx_data[1:0] != 2'b00) begin
              data_ctl  = load_word(NAK_WORD);
              rsp_cnt_d = RSP_CNT_W'(1);
              state_d   = RESP;
            end else begin
              state_d = BUS_ADDR;
            end
          end
        end
      end

      WDATA: begin
        if (rx_fire) begin
          data_ctl.shift = 1'b1;
          cnt_d          = cnt_q + CNT_W'(1);
          if (last_byte) begin
            if (addr_q[1:0] != 2'b00) begin
              data_ctl  = load_word(NAK_WORD);
              rsp_cnt_d = RSP_CNT_W'(1);
              state_d   = RESP;
            end else begin
              state_d = BUS_ADDR;
            end
          end
        end
      end

      BUS_ADDR: begin
        if (HREADY) begin
          state_d = BUS_DATA;
        end
      end

      BUS_DATA: begin
        if (HREADY) begin
          state_d = RESP;
          if (HRESP) begin
            data_ctl  = load_word(NAK_WORD);
            rsp_cnt_d = RSP_CNT_W'(1);
          end else if (write_q) begin
            data_ctl  = load_word(ACK_WORD);
            rsp_cnt_d = RSP_CNT_W'(1);
          end else begin
            data_ctl  = load_word(HRDATA);
            rsp_cnt_d = RSP_CNT_W'(4);
          end
        end
      end

      RESP: begin
        if (tx_fire) begin
          data_ctl.shift = 1'b1;
          rsp_cnt_d      = rsp_cnt_q - RSP_CNT_W'(1);
          if (rsp_cnt_q == RSP_CNT_W'(1)) begin
            state_d = CMD;
          end
        end
      end

      default: begin
        state_d = CMD;
      end
    endcase
  end

  // State register; handshake and bus-control outputs are registered from the next state.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q   <= CMD;
      cnt_q     <= '0;
      rsp_cnt_q <= '0;
      write_q   <= 1'b0;
      rx_ready  <= 1'b0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      HTRANS    <= HTRANS_IDLE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      write_q   <= write_d;
      rx_ready  <= (state_d == CMD) || (state_d == ADDR) || (state_d == WDATA);
      tx_valid  <= (state_d == RESP);
      busy      <= (state_d != CMD);
      HTRANS    <= (state_d == BUS_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end
  end

endmodule

// File: doc/uart_ahb_bridge.md
UART_AHB_BRIDGE -- requirements
Module: uart_ahb_bridge

Interface
REQ-001 SHALL have parameter ACK_BYTE, default 8'h06, the write-success response byte.
REQ-002 SHALL have parameter NAK_BYTE, default 8'h15, the error/unknown-command response byte.
REQ-003 SHALL use one clock and a synchronous, active-low reset.
REQ-004 SHALL have port HCLK  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port HRESETn  in  1  synchronous active-low reset.
REQ-006 SHALL have ports rx_data  in  8 and rx_valid  in  1: incoming command byte stream.
REQ-007 SHALL have port rx_ready  out  1: byte consumed when rx_valid & rx_ready at a clock edge.
REQ-008 SHALL have ports tx_data  out  8 and tx_valid  out  1: response byte stream.
REQ-009 SHALL have port tx_ready  in  1: response byte accepted when tx_valid & tx_ready at a clock edge.
REQ-010 SHALL have AHB-Lite master outputs HADDR 32, HTRANS 2, HWRITE 1, HSIZE 3, HWDATA 32.
REQ-011 SHALL have AHB-Lite master inputs HRDATA 32, HREADY 1, HRESP 1.
REQ-012 SHALL have port busy  out  1: high in every state except CMD.

Function
REQ-013 SHALL implement states CMD, ADDR, WDATA, BUS_ADDR, BUS_DATA, RESP.
REQ-014 CMD: rx_ready=1; 8'h57 ('W') or 8'h52 ('R') -> ADDR, clearing the byte counter; any other byte -> RESP with single byte NAK_BYTE.
REQ-015 ADDR: rx_ready=1; accept 4 bytes, MSB first, into a 32-bit address register; after the 4th byte: write -> WDATA, read -> BUS_ADDR.
REQ-016 WDATA: rx_ready=1; accept 4 bytes MSB first into the write-data register; after the 4th byte -> BUS_ADDR.
REQ-017 An address with [1:0] != 2'b00 SHALL skip the bus and go to RESP with NAK_BYTE once its last byte (address for read, data for write) is received.
REQ-018 rx_ready SHALL be 0 in BUS_ADDR, BUS_DATA and RESP; no byte is lost or consumed there.
REQ-019 BUS_ADDR: drive HTRANS=2'b10 (NONSEQ), HADDR=address, HWRITE per command, HSIZE=3'b010; stay while HREADY=0; on HREADY=1 -> BUS_DATA.
REQ-020 BUS_DATA: HTRANS=2'b00 (IDLE); HWDATA=write-data register (held for the whole phase); stay while HREADY=0.
REQ-021 BUS_DATA completion (HREADY=1): HRESP=1 -> RESP with NAK_BYTE; write with HRESP=0 -> RESP with ACK_BYTE; read with HRESP=0 -> capture HRDATA, RESP with those 4 bytes, MSB first.
REQ-022 Outside BUS_ADDR, HTRANS SHALL be 2'b00; at most one transfer is outstanding.
REQ-023 RESP: tx_valid=1; tx_data SHALL stay stable until accepted; after the last byte is accepted -> CMD.
REQ-024 tx_valid SHALL be 0 outside RESP; tx_ready is ignored there.
REQ-025 Back-to-back commands SHALL be legal; the first byte of the next command is accepted no earlier than the cycle after returning to CMD.
REQ-026 Latency: write with HREADY always 1 SHALL present ACK 3 cycles after the 9th command byte is accepted (ADDR/WDATA->BUS_ADDR->BUS_DATA->RESP).

Reset
REQ-027 On HRESETn=0 at a clock edge SHALL enter CMD, including mid-command or mid-transfer; partial commands are discarded.
REQ-028 Reset values: HTRANS=2'b00, HADDR=0, HWRITE=0, HSIZE=3'b010, HWDATA=0, rx_ready=0 in the reset cycle then 1, tx_valid=0, tx_data=0, busy=0, counters 0.

Structure
REQ-029 A shared package SHALL hold the state enum, command codes 8'h57/8'h52, HTRANS_IDLE/HTRANS_NONSEQ and HSIZE_WORD constants.
REQ-030 SHALL be a single module; one natural sub-module, byte_shift32 (4-byte MSB-first shift/serialise register), SHALL be used for address, write-data and read-data handling.

Verification
REQ-031 'W',00,00,00,10,DE,AD,BE,EF, HREADY=1 -> one NONSEQ write HADDR=32'h10, HWDATA=32'hDEADBEEF, response 8'h06.
REQ-032 'R',00,00,00,04, slave returns 32'h12345678 after 3 HREADY-low cycles -> HADDR held for the whole wait, response 12,34,56,78.
REQ-033 'W' to 32'h00000002 -> no HTRANS NONSEQ at all, response 8'h15.
REQ-034 Byte 8'h41 -> response 8'h15; next 'R' command is processed normally.
REQ-035 Read with HRESP=1 at completion -> response 8'h15 only; tx_ready held low 5 cycles -> tx_data stable, no drop.
REQ-036 HRESETn pulsed after 2 address bytes -> busy=0, HTRANS=00; next full 'W' completes with 8'h06.
